// File: rtl/set_assoc_cache.sv
// Two-way set-associative read cache with LRU replacement and block fill from memory.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module set_assoc_cache #(
  parameter int ADDR_W    = 15,
  parameter int WORD_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int SETS      = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_inv,
  input  logic [ADDR_W-1:0]           cpu_addr,
  output logic [WORD_W-1:0]           cpu_rdata,
  output logic                        cpu_ready,
  output logic                        cpu_hit,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic [WORD_W*BLK_WORDS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 miss_cnt
`endif
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BLK_W = WORD_W * BLK_WORDS;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;

  state_t             state_r, state_nxt_s;
  logic [SETS-1:0]    valid0_r, valid1_r, lru_r;
  logic [TAG_W-1:0]   tag0_r [SETS];
  logic [TAG_W-1:0]   tag1_r [SETS];
  logic [BLK_W-1:0]   data0_r [SETS];
  logic [BLK_W-1:0]   data1_r [SETS];
  logic [ADDR_W-1:0]  addr_r;
  logic               victim_r, resp_hit_r;
  logic [WORD_W-1:0]  resp_word_r;

  logic [IDX_W-1:0]   req_idx_s, in_idx_s;
  logic [TAG_W-1:0]   req_tag_s, in_tag_s;
  logic [OFF_W-1:0]   req_off_s;
  logic               hit0_s, hit1_s, hit_s, victim_s, inv0_s, inv1_s;
  logic               mem_req_nxt_s, cpu_ready_nxt_s, cpu_hit_nxt_s, resp_hit_nxt_s;
  logic [ADDR_W-1:0]  mem_addr_nxt_s;
  logic [WORD_W-1:0]  cpu_rdata_nxt_s, resp_word_nxt_s;

  function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] blk,
                                                input logic [OFF_W-1:0] off);
    word_of = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      if (off == OFF_W'(i)) word_of = blk[i*WORD_W +: WORD_W];
    end
  endfunction

  assign req_off_s = addr_r[OFF_W-1:0];
  assign req_idx_s = addr_r[OFF_W +: IDX_W];
  assign req_tag_s = addr_r[ADDR_W-1 -: TAG_W];
  assign in_idx_s  = cpu_addr[OFF_W +: IDX_W];
  assign in_tag_s  = cpu_addr[ADDR_W-1 -: TAG_W];

  assign hit0_s = valid0_r[req_idx_s] && (tag0_r[req_idx_s] == req_tag_s);
  assign hit1_s = valid1_r[req_idx_s] && (tag1_r[req_idx_s] == req_tag_s);
  assign hit_s  = hit0_s || hit1_s;
  assign inv0_s = valid0_r[in_idx_s] && (tag0_r[in_idx_s] == in_tag_s);
  assign inv1_s = valid1_r[in_idx_s] && (tag1_r[in_idx_s] == in_tag_s);

  // Victim: an empty way wins (way 0 first), otherwise the way the LRU bit names.
  always_comb begin
    if (!valid0_r[req_idx_s]) begin
      victim_s = 1'b0;
    end else if (!valid1_r[req_idx_s]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r[req_idx_s];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; an invalidate swallows a simultaneous request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_inv)      state_nxt_s = IDLE;
        else if (cpu_req) state_nxt_s = LOOKUP;
        else              state_nxt_s = IDLE;
      end
      LOOKUP:  state_nxt_s = hit_s ? RESP : FILL;
      FILL:    state_nxt_s = mem_ack ? RESP : FILL;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the pending response word.
  always_comb begin
    mem_req_nxt_s   = mem_req;
    mem_addr_nxt_s  = mem_addr;
    cpu_rdata_nxt_s = cpu_rdata;
    cpu_ready_nxt_s = 1'b0;
    cpu_hit_nxt_s   = 1'b0;
    resp_hit_nxt_s  = resp_hit_r;
    resp_word_nxt_s = resp_word_r;
    case (state_r)
      LOOKUP: begin
        if (hit_s) begin
          resp_hit_nxt_s  = 1'b1;
          resp_word_nxt_s = word_of(hit0_s ? data0_r[req_idx_s] : data1_r[req_idx_s], req_off_s);
        end else begin
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      FILL: begin
        if (mem_ack) begin
          mem_req_nxt_s   = 1'b0;
          resp_hit_nxt_s  = 1'b0;
          resp_word_nxt_s = word_of(mem_rdata, req_off_s);
        end else begin
          mem_req_nxt_s = 1'b1;
        end
      end
      RESP: begin
        cpu_ready_nxt_s = 1'b1;
        cpu_hit_nxt_s   = resp_hit_r;
        cpu_rdata_nxt_s = resp_word_r;
      end
      default: begin
        mem_req_nxt_s = mem_req;
      end
    endcase
  end

  // Output and request-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_hit     <= 1'b0;
      resp_hit_r  <= 1'b0;
      resp_word_r <= '0;
      addr_r      <= '0;
      victim_r    <= 1'b0;
    end else begin
      mem_req     <= mem_req_nxt_s;
      mem_addr    <= mem_addr_nxt_s;
      cpu_rdata   <= cpu_rdata_nxt_s;
      cpu_ready   <= cpu_ready_nxt_s;
      cpu_hit     <= cpu_hit_nxt_s;
      resp_hit_r  <= resp_hit_nxt_s;
      resp_word_r <= resp_word_nxt_s;
      if (state_r == IDLE && cpu_req && !cpu_inv) addr_r <= cpu_addr;
      if (state_r == LOOKUP && !hit_s) victim_r <= victim_s;
    end
  end

  // Valid and LRU bookkeeping; each touch points LRU at the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_r <= '0;
      valid1_r <= '0;
      lru_r    <= '0;
    end else begin
      if (state_r == IDLE && cpu_inv) begin
        if (inv0_s) valid0_r[in_idx_s] <= 1'b0;
        if (inv1_s) valid1_r[in_idx_s] <= 1'b0;
      end
      if (state_r == LOOKUP && hit_s) lru_r[req_idx_s] <= hit0_s;
      if (state_r == FILL && mem_ack) begin
        if (victim_r) valid1_r[req_idx_s] <= 1'b1;
        else          valid0_r[req_idx_s] <= 1'b1;
        lru_r[req_idx_s] <= ~victim_r;
      end
    end
  end

  // Tag and data arrays are written only on fill and need no reset.
  always_ff @(posedge clk) begin
    if (state_r == FILL && mem_ack) begin
      if (victim_r) begin
        tag1_r[req_idx_s]  <= req_tag_s;
        data1_r[req_idx_s] <= mem_rdata;
      end else begin
        tag0_r[req_idx_s]  <= req_tag_s;
        data0_r[req_idx_s] <= mem_rdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Hit/miss counters advance once per resolved lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (state_r == LOOKUP) begin
      if (hit_s) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomised self-checking bench for set_assoc_cache against a timestamp-LRU cache model.
// Counter ports are connected and checked when CACHE_STATS_EN is defined.
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_inv, cpu_ready, cpu_hit, mem_req, mem_ack;
  logic [14:0]  cpu_addr, mem_addr;
  logic [31:0]  cpu_rdata;
  logic [127:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: per set and way a valid flag, tag and last-use time.
  bit          m_valid [2][512];
  int          m_tag   [2][512];
  int          m_ts    [2][512];
  int          m_now   = 0;
  int          m_hits  = 0;
  int          m_miss  = 0;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_inv(cpu_inv), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return 32'hC0DE_0000 ^ {a, 2'b01, a};
  endfunction

  function automatic logic [127:0] mem_blk(input logic [14:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = mem_word({a[14:2], 2'(i)});
    return b;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 512; s++) m_valid[w][s] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endfunction

  // Returns 1 on hit; on miss fills the empty or least-recently-used way.
  function automatic bit model_access(input logic [14:0] a);
    int idx, tg, v;
    idx = int'(a[10:2]);
    tg  = int'(a[14:11]);
    m_now++;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[w][idx] && m_tag[w][idx] == tg) begin
        m_ts[w][idx] = m_now;
        m_hits++;
        return 1'b1;
      end
    end
    if (!m_valid[0][idx])      v = 0;
    else if (!m_valid[1][idx]) v = 1;
    else                       v = (m_ts[0][idx] < m_ts[1][idx]) ? 0 : 1;
    m_valid[v][idx] = 1'b1;
    m_tag[v][idx]   = tg;
    m_ts[v][idx]    = m_now;
    m_miss++;
    return 1'b0;
  endfunction

  function automatic void model_inv(input logic [14:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][int'(a[10:2])] && m_tag[w][int'(a[10:2])] == int'(a[14:11]))
        m_valid[w][int'(a[10:2])] = 1'b0;
  endfunction

  task automatic do_req(input logic [14:0] a);
    bit          exp_hit, done, acked, saw_mem;
    int          lat, wait_n, ack_dly, exp_lat;
    logic [31:0] got;
    exp_hit = model_access(a);
    ack_dly = $urandom_range(0, 3);
    @(negedge clk);
    cpu_req = 1'b1; cpu_inv = 1'b0; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 15'($urandom);
    lat = 0; wait_n = 0; done = 1'b0; acked = 1'b0; saw_mem = 1'b0; got = 32'd0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        done = 1'b1;
        got  = cpu_rdata;
        check_val("hit_flag", {31'd0, cpu_hit}, {31'd0, exp_hit});
        check_val("rdata", cpu_rdata, mem_word(a));
        check_val("mem_req_low_at_ready", {31'd0, mem_req}, 32'd0);
      end else if (!acked && (mem_req || saw_mem)) begin
        check_val("mem_req_hold", {31'd0, mem_req}, 32'd1);
        check_val("mem_addr", {17'd0, mem_addr}, {17'd0, a[14:2], 2'b00});
        saw_mem = 1'b1;
        if (wait_n == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_blk(a);
          acked     = 1'b1;
        end else begin
          wait_n++;
        end
      end
    end
    mem_ack = 1'b0;
    if (!done) check_val("ready_timeout", 32'd0, 32'd1);
    exp_lat = exp_hit ? 2 : 3 + ack_dly;
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("mem_req_seen", {31'd0, saw_mem}, {31'd0, !exp_hit});
    @(posedge clk); #1;
    check_val("ready_one_cycle", {31'd0, cpu_ready}, 32'd0);
    check_val("rdata_hold", cpu_rdata, got);
  endtask

  task automatic do_inv(input logic [14:0] a, input bit with_req);
    model_inv(a);
    @(negedge clk);
    cpu_inv = 1'b1; cpu_req = with_req; cpu_addr = a;
    @(posedge clk); #1;
    cpu_inv = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("inv_no_ready", {31'd0, cpu_ready}, 32'd0);
      check_val("inv_no_mem_req", {31'd0, mem_req}, 32'd0);
    end
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check_val("hit_cnt", hit_cnt, 32'(m_hits));
    check_val("miss_cnt", miss_cnt, 32'(m_miss));
`endif
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cpu_req = 1'b0; cpu_inv = 1'b0; cpu_addr = 15'd0;
    mem_ack = 1'b0; mem_rdata = 128'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check_val("rst_hit", {31'd0, cpu_hit}, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    check_val("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed: fill then hit in the same block.
    do_req(15'h0005);
    do_req(15'h0006);
    // Directed: LRU victim choice in one set.
    do_req(15'h0804);
    do_req(15'h0004);
    do_req(15'h1004);
    do_req(15'h0004);
    do_req(15'h0804);
    // Directed: invalidate wins over a same-cycle request.
    do_req(15'h0004);
    do_inv(15'h0004, 1'b1);
    do_req(15'h0004);
    check_stats();

    // Directed: reset in the middle of a fill.
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 15'h0010;
    @(posedge clk); #1; cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_req;
    end
    check_val("rstfill_mem_req_seen", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("rstfill_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rstfill_mem_addr", {17'd0, mem_addr}, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = mem_blk(15'h0010);
    @(negedge clk); mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("stale_ack_no_ready", {31'd0, cpu_ready}, 32'd0);
    end
    do_req(15'h0010);
    check_stats();

    // Random traffic over a few conflicting sets.
    for (int n = 0; n < 200; n++) begin
      logic [14:0] a;
      a = {4'($urandom_range(0, 3)), 9'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) < 2) do_inv(a, 1'($urandom_range(0, 1)));
      else                          do_req(a);
    end
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
